// File: rtl/tnoc_port_terminator_pkg.sv
// rtl/tnoc_port_terminator_pkg.sv - shared tnoc fabric typedefs, port terminator state enum and defaults
package tnoc_port_terminator_pkg;

  // Fabric configuration; only the virtual channel count is needed by the terminator.
  typedef struct packed {
    int unsigned vcs;
  } tnoc_config;

  localparam tnoc_config TNOC_DEFAULT_CONFIG = '{vcs: 32'd2};

  // Router port flavour, forwarded to the flit interfaces.
  typedef enum logic [1:0] {
    TNOC_LOCAL_PORT    = 2'd0,
    TNOC_INTERNAL_PORT = 2'd1
  } tnoc_port_type;

  localparam int TNOC_DATA_WIDTH = 32;

  // One flit as seen on a single VC lane.
  typedef struct packed {
    logic                       head;
    logic                       tail;
    logic [TNOC_DATA_WIDTH-1:0] data;
  } tnoc_flit;

  // Per-VC framing state of the terminator.
  typedef enum logic {
    IDLE      = 1'b0,
    IN_PACKET = 1'b1
  } tnoc_vc_state;

  localparam int TNOC_TERMINATOR_COUNT_WIDTH = 16;

  // Saturating increment: all-ones is sticky so a counter never wraps.
  function automatic logic [63:0] tnoc_sat_inc(input logic [63:0] value, input logic [63:0] max);
    return (value == max) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/tnoc_port_terminator_if.sv
// rtl/tnoc_port_terminator_if.sv - per-VC flit handshake interface with initiator/target modports
interface tnoc_port_terminator_if
  import tnoc_port_terminator_pkg::*;
#(
  parameter tnoc_config    CONFIG    = TNOC_DEFAULT_CONFIG,
  parameter tnoc_port_type PORT_TYPE = TNOC_LOCAL_PORT
);

  localparam int VCS = int'(CONFIG.vcs);

  // Port flavour carried along so a connected block can specialise on it.
  localparam tnoc_port_type TYPE = PORT_TYPE;

  logic     [VCS-1:0] valid;
  logic     [VCS-1:0] ready;
  logic     [VCS-1:0] vc_available;
  tnoc_flit [VCS-1:0] flit;

  modport initiator (
    output valid,
    output flit,
    input  ready,
    input  vc_available
  );

  modport target (
    input  valid,
    input  flit,
    output ready,
    output vc_available
  );

  modport master (
    output valid,
    output flit,
    input  ready,
    input  vc_available
  );

  modport slave (
    input  valid,
    input  flit,
    output ready,
    output vc_available
  );

endinterface

// File: rtl/tnoc_port_terminator_vc_monitor.sv
// rtl/tnoc_port_terminator_vc_monitor.sv - one VC's framing FSM, saturating drop counter and sticky error flag
module tnoc_port_terminator_vc_monitor
  import tnoc_port_terminator_pkg::*;
#(
  parameter int COUNT_WIDTH = TNOC_TERMINATOR_COUNT_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_clear,
  input  logic                   i_xfer,
  input  logic                   i_head,
  input  logic                   i_tail,
  output logic [COUNT_WIDTH-1:0] o_count,
  output logic                   o_error,
  output logic                   o_busy
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  tnoc_vc_state           state_q;
  tnoc_vc_state           state_d;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;
  logic                   error_q;
  logic                   error_d;
  logic                   count_event;
  logic                   error_event;
  logic [63:0]            count_inc;

  // Framing decisions for the flit transferred this cycle: next state, whether a packet completes, whether framing is broken.
  always_comb begin
    state_d     = state_q;
    count_event = 1'b0;
    error_event = 1'b0;
    if (i_xfer) begin
      unique case (state_q)
        IDLE: begin
          if (!i_head) begin
            error_event = 1'b1;
          end else if (i_tail) begin
            count_event = 1'b1;
          end else begin
            state_d = IN_PACKET;
          end
        end
        IN_PACKET: begin
          // A head here aborts the open packet (never counted) and starts a new one.
          if (i_head) begin
            error_event = 1'b1;
          end
          if (i_tail) begin
            state_d     = IDLE;
            count_event = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Counter and flag next values; clear overrides any event landing in the same cycle.
  always_comb begin
    count_inc = tnoc_sat_inc(64'(count_q), 64'(COUNT_MAX));
    count_d   = count_q;
    error_d   = error_q;
    if (i_clear) begin
      count_d = '0;
      error_d = 1'b0;
    end else begin
      if (count_event) begin
        count_d = count_inc[COUNT_WIDTH-1:0];
      end
      if (error_event) begin
        error_d = 1'b1;
      end
    end
  end

  // State, counter and flag registers; reset drops any open packet silently.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

  assign o_count = count_q;
  assign o_error = error_q;
  assign o_busy  = (state_q == IN_PACKET);

endmodule

// File: rtl/tnoc_port_terminator.sv
// rtl/tnoc_port_terminator.sv - sink for unused router ports; optional ready throttle via TNOC_PORT_TERMINATOR_THROTTLE_EN
module tnoc_port_terminator
  import tnoc_port_terminator_pkg::*;
#(
  parameter tnoc_config    CONFIG          = TNOC_DEFAULT_CONFIG,
  parameter tnoc_port_type PORT_TYPE       = TNOC_LOCAL_PORT,
  parameter int            COUNT_WIDTH     = TNOC_TERMINATOR_COUNT_WIDTH,
  parameter int            THROTTLE_PERIOD = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  tnoc_port_terminator_if.target                flit_in_if,
  tnoc_port_terminator_if.initiator             flit_out_if,
  input  logic                                  i_clear,
  output logic [CONFIG.vcs*COUNT_WIDTH-1:0]     o_packet_count,
  output logic [CONFIG.vcs-1:0]                 o_protocol_error,
  output logic                                  o_busy
);

  localparam int VCS = int'(CONFIG.vcs);

  // Port flavour is fixed by the interfaces bound here; kept for hierarchy readability.
  localparam tnoc_port_type TYPE = PORT_TYPE;

  logic [VCS-1:0] ready_w;
  logic [VCS-1:0] busy_w;

`ifdef TNOC_PORT_TERMINATOR_THROTTLE_EN
  localparam int                 THR_W    = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;
  localparam logic [THR_W-1:0]   THR_LAST = THR_W'(THROTTLE_PERIOD - 1);

  logic [THR_W-1:0] throttle_q;
  logic [THR_W-1:0] throttle_d;
  logic             ready_q;
  logic             ready_d;

  // Free-running phase counter; ready is precomputed for the next phase so it leaves a flop directly.
  always_comb begin
    throttle_d = (throttle_q == THR_LAST) ? '0 : throttle_q + 1'b1;
    ready_d    = (throttle_d == '0);
  end

  // Throttle phase and registered ready; phase 0 right after reset accepts a flit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      throttle_q <= '0;
      ready_q    <= 1'b1;
    end else begin
      throttle_q <= throttle_d;
      ready_q    <= ready_d;
    end
  end

  assign ready_w = {VCS{ready_q}};
`else
  assign ready_w = '1;
`endif

  // Target side always advertises credit; initiator side never sends.
  assign flit_in_if.ready         = ready_w;
  assign flit_in_if.vc_available  = '1;
  assign flit_out_if.valid        = '0;
  assign flit_out_if.flit         = '0;

  for (genvar v = 0; v < VCS; v++) begin : g_vc
    tnoc_port_terminator_vc_monitor #(
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_monitor (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (i_clear),
      .i_xfer  (flit_in_if.valid[v] & ready_w[v]),
      .i_head  (flit_in_if.flit[v].head),
      .i_tail  (flit_in_if.flit[v].tail),
      .o_count (o_packet_count[v*COUNT_WIDTH +: COUNT_WIDTH]),
      .o_error (o_protocol_error[v]),
      .o_busy  (busy_w[v])
    );
  end

  assign o_busy = |busy_w;

endmodule

// File: tb/tb_tnoc_port_terminator.sv
// tb/tb_tnoc_port_terminator.sv - self-checking bench for tnoc_port_terminator
module tb_tnoc_port_terminator;
  import tnoc_port_terminator_pkg::*;

  localparam int VCS = 2;
  localparam int CW  = 4;
  localparam int P   = 4;
  localparam tnoc_config CFG = '{vcs: 32'd2};
  localparam int CMAX = (1 << CW) - 1;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic [VCS*CW-1:0] pkt_count;
  logic [VCS-1:0]    perr;
  logic              busy;

  tnoc_port_terminator_if #(.CONFIG(CFG), .PORT_TYPE(TNOC_LOCAL_PORT)) in_if ();
  tnoc_port_terminator_if #(.CONFIG(CFG), .PORT_TYPE(TNOC_LOCAL_PORT)) out_if ();

  tnoc_port_terminator #(
    .CONFIG          (CFG),
    .PORT_TYPE       (TNOC_LOCAL_PORT),
    .COUNT_WIDTH     (CW),
    .THROTTLE_PERIOD (P)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .flit_in_if       (in_if),
    .flit_out_if      (out_if),
    .i_clear          (clear),
    .o_packet_count   (pkt_count),
    .o_protocol_error (perr),
    .o_busy           (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: packet-open flag, dropped count and error flag per VC.
  int exp_cnt  [VCS];
  bit exp_err  [VCS];
  bit open_pkt [VCS];
  int tcyc       = 0;
  int posedges   = 0;
  bit model_live = 1'b0;
  bit last_xfer  = 1'b0;

  function automatic bit exp_ready();
`ifdef TNOC_PORT_TERMINATOR_THROTTLE_EN
    return (tcyc % P) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_flit(input int v, input bit h, input bit t);
    if (!open_pkt[v]) begin
      if (!h) exp_err[v] = 1'b1;
      else if (t) begin
        if (exp_cnt[v] < CMAX) exp_cnt[v]++;
      end else open_pkt[v] = 1'b1;
    end else begin
      if (h) exp_err[v] = 1'b1;
      if (t) begin
        open_pkt[v] = 1'b0;
        if (exp_cnt[v] < CMAX) exp_cnt[v]++;
      end
    end
  endtask

  // Model update on each rising edge from the inputs presented that cycle.
  always @(posedge clk) begin
    posedges++;
    if (!rst_n) begin
      for (int v = 0; v < VCS; v++) begin
        exp_cnt[v] = 0; exp_err[v] = 1'b0; open_pkt[v] = 1'b0;
      end
      tcyc = 0;
      last_xfer = 1'b0;
    end else begin
      last_xfer = 1'b0;
      if (exp_ready()) begin
        for (int v = 0; v < VCS; v++) begin
          if (in_if.valid[v]) begin
            last_xfer = 1'b1;
            model_flit(v, in_if.flit[v].head, in_if.flit[v].tail);
          end
        end
      end
      if (clear) begin
        for (int v = 0; v < VCS; v++) begin
          exp_cnt[v] = 0; exp_err[v] = 1'b0;
        end
      end
      tcyc++;
    end
    model_live = 1'b1;
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic [VCS*CW-1:0] ec;
    logic [VCS-1:0]    ee;
    logic              eb;
    if (model_live) begin
      eb = 1'b0;
      for (int v = 0; v < VCS; v++) begin
        ec[v*CW +: CW] = exp_cnt[v][CW-1:0];
        ee[v] = exp_err[v];
        eb = eb | open_pkt[v];
      end
      chk("cyc_count", 64'(pkt_count), 64'(ec));
      chk("cyc_error", 64'(perr), 64'(ee));
      chk("cyc_busy", 64'(busy), 64'(eb));
      chk("cyc_ready", 64'(in_if.ready), 64'({VCS{exp_ready()}}));
      chk("cyc_vc_avail", 64'(in_if.vc_available), 64'({VCS{1'b1}}));
      chk("cyc_out_valid", 64'(out_if.valid), 64'd0);
      chk("cyc_out_flit_zero", 64'(out_if.flit == '0), 64'd1);
    end
  end

  task automatic drive(input logic [VCS-1:0] vld, input logic [VCS-1:0] hd,
                       input logic [VCS-1:0] tl, input logic clr);
    int waited;
    waited = 0;
    for (int v = 0; v < VCS; v++) begin
      in_if.valid[v] = vld[v];
      in_if.flit[v]  = '{head: hd[v], tail: tl[v], data: $urandom()};
    end
    clear = clr;
    do begin
      @(negedge clk);
      waited++;
    end while (vld != '0 && !last_xfer && waited < 64);
    if (vld != '0 && !last_xfer) begin
      n_tests++;
      n_fail++;
      $display("FAIL drive_timeout: got no transfer in %0d cycles, required one", waited);
    end
    in_if.valid = '0;
    clear = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int s;
    in_if.valid         = '0;
    in_if.flit          = '0;
    out_if.ready        = '1;
    out_if.vc_available = '1;
    do_reset();

    // Reset state, pinned with literals.
    chk("rst_count", 64'(pkt_count), 64'd0);
    chk("rst_error", 64'(perr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(in_if.ready), 64'h3);
    chk("rst_vc_avail", 64'(in_if.vc_available), 64'h3);
    chk("rst_out_valid", 64'(out_if.valid), 64'd0);

`ifdef TNOC_PORT_TERMINATOR_THROTTLE_EN
    // 4-flit packet with ready 1 in 4 cycles completes 13 edges after the head is offered.
    s = posedges;
    drive(2'b01, 2'b01, 2'b00, 1'b0);
    drive(2'b01, 2'b00, 2'b00, 1'b0);
    drive(2'b01, 2'b00, 2'b00, 1'b0);
    drive(2'b01, 2'b00, 2'b01, 1'b0);
    chk("thr_cycles", 64'(posedges - s), 64'd13);
    chk("thr_count", 64'(pkt_count[CW-1:0]), 64'd1);
    do_reset();
`else
    s = 0;
`endif

    // Back-to-back single-flit packets on VC0.
    drive(2'b01, 2'b01, 2'b01, 1'b0);
    chk("b2b_count1", 64'(pkt_count[CW-1:0]), 64'd1);
    drive(2'b01, 2'b01, 2'b01, 1'b0);
    chk("b2b_count2", 64'(pkt_count[CW-1:0]), 64'd2);
    drive(2'b01, 2'b01, 2'b01, 1'b0);
    chk("b2b_count3", 64'(pkt_count[CW-1:0]), 64'd3);
    chk("b2b_busy", 64'(busy), 64'd0);

    // VC1 4-flit packet interleaved with VC0 2-flit packet.
    drive(2'b10, 2'b10, 2'b00, 1'b0);
    chk("il_busy_head", 64'(busy), 64'd1);
    drive(2'b11, 2'b01, 2'b00, 1'b0);
    drive(2'b10, 2'b00, 2'b00, 1'b0);
    chk("il_count1_mid", 64'(pkt_count[2*CW-1:CW]), 64'd0);
    drive(2'b01, 2'b00, 2'b01, 1'b0);
    chk("il_count0_tail", 64'(pkt_count[CW-1:0]), 64'd4);
    chk("il_busy_vc1_open", 64'(busy), 64'd1);
    drive(2'b10, 2'b00, 2'b10, 1'b0);
    chk("il_count1_tail", 64'(pkt_count[2*CW-1:CW]), 64'd1);
    chk("il_busy_done", 64'(busy), 64'd0);

    // Framing errors: body while idle, then head inside an open packet.
    drive(2'b01, 2'b00, 2'b00, 1'b0);
    chk("err_body_idle_flag", 64'(perr), 64'h1);
    chk("err_body_idle_count", 64'(pkt_count[CW-1:0]), 64'd4);
    drive(2'b10, 2'b10, 2'b00, 1'b0);
    drive(2'b10, 2'b10, 2'b00, 1'b0);
    chk("err_head_open_flag", 64'(perr), 64'h3);
    drive(2'b10, 2'b00, 2'b10, 1'b0);
    chk("err_restart_count", 64'(pkt_count[2*CW-1:CW]), 64'd2);

    // Clear alone.
    drive(2'b00, 2'b00, 2'b00, 1'b1);
    chk("clr_count", 64'(pkt_count), 64'd0);
    chk("clr_error", 64'(perr), 64'd0);

    // Saturation with a 4-bit counter.
    for (int i = 0; i < 20; i++) drive(2'b01, 2'b01, 2'b01, 1'b0);
    chk("sat_count", 64'(pkt_count[CW-1:0]), 64'd15);

    // Clear coinciding with a counted tail.
    drive(2'b01, 2'b01, 2'b00, 1'b0);
    drive(2'b01, 2'b00, 2'b01, 1'b1);
    chk("clr_tail_count", 64'(pkt_count[CW-1:0]), 64'd0);
    chk("clr_tail_busy", 64'(busy), 64'd0);

    // Reset mid-packet: nothing counted or flagged; the orphan tail is an error.
    drive(2'b10, 2'b10, 2'b00, 1'b0);
    chk("mid_busy", 64'(busy), 64'd1);
    do_reset();
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_error", 64'(perr), 64'd0);
    drive(2'b10, 2'b00, 2'b10, 1'b0);
    chk("mid_orphan_error", 64'(perr), 64'h2);
    chk("mid_orphan_count", 64'(pkt_count), 64'd0);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
